// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Purpose  : Registered RV decode stage between fetch and execute. Decodes
//            a 32-bit instruction into register ids, an XLEN-wide
//            sign-extended immediate and a 16-bit packed control word. It has
//            valid/ready handshakes on both sides and a 2-entry (main + skid)
//            buffer, so execute stalls never drop or duplicate instructions.
//            flush discards everything buffered plus any same-cycle input.
// Ports    : clk, rst (sync, active-high), flush
//            in_valid / in_ready (registered) / in_instr[31:0] / in_pc
//            out_valid / out_ready / out_pc / rs1_id / rs2_id / rd_id /
//            mem_width / imm[XLEN-1:0] / ctrl[15:0]
//            dec_count / illegal_count  (only with DECODE_STATS_EN defined)
// Config   : `define DECODE_STATS_EN adds the two 32-bit statistics counters.
// Revision : 1.0 - initial release
// ============================================================================
module decode_stage #(
   parameter int XLEN = 32,
   parameter int PC_W = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [PC_W-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [PC_W-1:0] out_pc,
   output logic [4:0]      rs1_id,
   output logic [4:0]      rs2_id,
   output logic [4:0]      rd_id,
   output logic [2:0]      mem_width,
   output logic [XLEN-1:0] imm,
   output logic [15:0]     ctrl
`ifdef DECODE_STATS_EN
   ,
   output logic [31:0]     dec_count,
   output logic [31:0]     illegal_count
`endif
);

   localparam logic [1:0] S_EMPTY = 2'd0;
   localparam logic [1:0] S_ONE   = 2'd1;
   localparam logic [1:0] S_TWO   = 2'd2;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0100;
   localparam logic [3:0] ALU_OR   = 4'b0101;
   localparam logic [3:0] ALU_XOR  = 4'b0110;
   localparam logic [3:0] ALU_SHL  = 4'b1000;
   localparam logic [3:0] ALU_SHR  = 4'b1010;
   localparam logic [3:0] ALU_SHA  = 4'b1011;
   localparam logic [3:0] ALU_SLT  = 4'b1100;
   localparam logic [3:0] ALU_SLTU = 4'b1101;
   localparam logic [3:0] ALU_B    = 4'b1111;

   localparam logic [1:0] SRC2_RS2 = 2'b00;
   localparam logic [1:0] SRC2_IMM = 2'b01;
   localparam logic [1:0] SRC2_4   = 2'b11;

   localparam logic [1:0] TYPE_PC4    = 2'b00;
   localparam logic [1:0] TYPE_PCIMM  = 2'b01;
   localparam logic [1:0] TYPE_RS1IMM = 2'b11;

   // {pc, rs1, rs2, rd, funct3, imm, ctrl}
   localparam int BW = PC_W + 15 + 3 + XLEN + 16;

   // ------------------------------------------------------------------
   // Combinational decode of the incoming instruction
   // ------------------------------------------------------------------
   logic [6:0]         w_opcode;
   logic [2:0]         w_f3;
   logic [6:0]         w_f7;
   logic [6:0]         w_sh_upper;
   logic [3:0]         w_alu;
   logic               w_m2r, w_mw, w_src1, w_rw, w_br, w_inv, w_jump, w_ill;
   logic [1:0]         w_src2, w_type;
   logic signed [31:0] w_imm32;
   logic [15:0]        w_ctrl;
   logic [XLEN-1:0]    w_imm;
   logic [BW-1:0]      w_bundle;

   assign w_opcode = in_instr[6:0];
   assign w_f3     = in_instr[14:12];
   assign w_f7     = in_instr[31:25];
   // Bits above the shamt field; RV64 shamt is 6 bits so bit 25 belongs to it.
   assign w_sh_upper = (XLEN == 64) ? {in_instr[31:26], 1'b0} : in_instr[31:25];

   always_comb begin
      w_alu   = ALU_ADD;
      w_m2r   = 1'b0;
      w_mw    = 1'b0;
      w_src1  = 1'b0;
      w_src2  = SRC2_RS2;
      w_rw    = 1'b0;
      w_br    = 1'b0;
      w_inv   = 1'b0;
      w_jump  = 1'b0;
      w_type  = TYPE_PC4;
      w_ill   = 1'b0;
      w_imm32 = '0;
      case (w_opcode)
         OP_R: begin
            w_rw = 1'b1;
            case ({w_f7, w_f3})
               {7'b0000000, 3'b000}: w_alu = ALU_ADD;
               {7'b0100000, 3'b000}: w_alu = ALU_SUB;
               {7'b0000000, 3'b001}: w_alu = ALU_SHL;
               {7'b0000000, 3'b010}: w_alu = ALU_SLT;
               {7'b0000000, 3'b011}: w_alu = ALU_SLTU;
               {7'b0000000, 3'b100}: w_alu = ALU_XOR;
               {7'b0000000, 3'b101}: w_alu = ALU_SHR;
               {7'b0100000, 3'b101}: w_alu = ALU_SHA;
               {7'b0000000, 3'b110}: w_alu = ALU_OR;
               {7'b0000000, 3'b111}: w_alu = ALU_AND;
               default:              w_ill = 1'b1;
            endcase
         end
         OP_I: begin
            w_rw    = 1'b1;
            w_src2  = SRC2_IMM;
            w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            case (w_f3)
               3'b000: w_alu = ALU_ADD;
               3'b010: w_alu = ALU_SLT;
               3'b011: w_alu = ALU_SLTU;
               3'b100: w_alu = ALU_XOR;
               3'b110: w_alu = ALU_OR;
               3'b111: w_alu = ALU_AND;
               3'b001: begin
                  w_alu = ALU_SHL;
                  w_ill = (w_sh_upper != 7'b0000000);
               end
               default: begin  // 3'b101
                  w_alu = in_instr[30] ? ALU_SHA : ALU_SHR;
                  w_ill = (w_sh_upper != 7'b0000000) && (w_sh_upper != 7'b0100000);
               end
            endcase
            // Shifts carry an unsigned shift amount, not a signed immediate.
            if (w_f3 == 3'b001 || w_f3 == 3'b101) begin
               w_imm32 = (XLEN == 64) ? {26'b0, in_instr[25:20]} : {27'b0, in_instr[24:20]};
            end
         end
         OP_LOAD: begin
            w_m2r   = 1'b1;
            w_rw    = 1'b1;
            w_src2  = SRC2_IMM;
            w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            case (w_f3)
               3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_ill = 1'b0;
               3'b011, 3'b110:                         w_ill = (XLEN != 64);
               default:                                w_ill = 1'b1;
            endcase
         end
         OP_STORE: begin
            w_mw    = 1'b1;
            w_src2  = SRC2_IMM;
            w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            case (w_f3)
               3'b000, 3'b001, 3'b010: w_ill = 1'b0;
               3'b011:                 w_ill = (XLEN != 64);
               default:                w_ill = 1'b1;
            endcase
         end
         OP_BRANCH: begin
            w_br    = 1'b1;
            w_type  = TYPE_PCIMM;
            w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                       in_instr[30:25], in_instr[11:8], 1'b0};
            case (w_f3)
               3'b000: w_alu = ALU_SUB;
               3'b001: begin w_alu = ALU_SUB;  w_inv = 1'b1; end
               3'b100: w_alu = ALU_SLT;
               3'b101: begin w_alu = ALU_SLT;  w_inv = 1'b1; end
               3'b110: w_alu = ALU_SLTU;
               3'b111: begin w_alu = ALU_SLTU; w_inv = 1'b1; end
               default: w_ill = 1'b1;
            endcase
         end
         OP_JAL: begin
            // rd <- pc + 4 through the ALU; target pc + imm.
            w_jump  = 1'b1;
            w_rw    = 1'b1;
            w_src1  = 1'b1;
            w_src2  = SRC2_4;
            w_type  = TYPE_PCIMM;
            w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                       in_instr[20], in_instr[30:21], 1'b0};
         end
         OP_JALR: begin
            w_jump  = 1'b1;
            w_rw    = 1'b1;
            w_src1  = 1'b1;
            w_src2  = SRC2_4;
            w_type  = TYPE_RS1IMM;
            w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            w_ill   = (w_f3 != 3'b000);
         end
         OP_AUIPC: begin
            w_rw    = 1'b1;
            w_src1  = 1'b1;
            w_src2  = SRC2_IMM;
            w_imm32 = {in_instr[31:12], 12'b0};
         end
         OP_LUI: begin
            w_alu   = ALU_B;
            w_rw    = 1'b1;
            w_src2  = SRC2_IMM;
            w_imm32 = {in_instr[31:12], 12'b0};
         end
         default: w_ill = 1'b1;
      endcase

      // The all-zero word is a pipeline bubble, checked before illegal.
      if (in_instr == 32'h0) begin
         w_ctrl  = 16'h0000;
         w_imm32 = '0;
      end else if (w_ill) begin
         w_ctrl  = 16'h8000;
         w_imm32 = '0;
      end else begin
         w_ctrl = {1'b0, w_type, w_jump, w_inv, w_br, w_rw, w_src2, w_src1,
                   w_mw, w_m2r, w_alu};
      end
   end

   // Signed cast: sign-extends the 32-bit immediate to XLEN.
   assign w_imm    = XLEN'(w_imm32);
   assign w_bundle = {in_pc, in_instr[19:15], in_instr[24:20], in_instr[11:7],
                      w_f3, w_imm, w_ctrl};

   // ------------------------------------------------------------------
   // Buffer control FSM
   // ------------------------------------------------------------------
   logic [1:0]    state_q, state_d;
   logic          in_ready_q, in_ready_d;
   logic [BW-1:0] main_q, main_d, skid_q;
   logic          w_in_fire, w_out_fire;
   logic          w_load_main, w_load_skid, w_main_from_skid;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         in_ready_q <= in_ready_d;
      end
   end

   // Next-state logic; flush overrides every other event.
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = S_EMPTY;
      end else begin
         case (state_q)
            S_EMPTY: if (w_in_fire) state_d = S_ONE;
            S_ONE: begin
               if (w_in_fire && !w_out_fire)      state_d = S_TWO;
               else if (w_out_fire && !w_in_fire) state_d = S_EMPTY;
            end
            S_TWO:   if (w_out_fire) state_d = S_ONE;
            default: state_d = S_EMPTY;
         endcase
      end
   end

   // Output / datapath-control logic
   always_comb begin
      out_valid        = (state_q != S_EMPTY);
      in_ready         = in_ready_q;
      w_in_fire        = in_valid && in_ready_q;
      w_out_fire       = out_valid && out_ready;
      in_ready_d       = (state_d != S_TWO);
      w_load_main      = 1'b0;
      w_load_skid      = 1'b0;
      w_main_from_skid = 1'b0;
      if (!flush) begin
         case (state_q)
            S_EMPTY: w_load_main = w_in_fire;
            S_ONE: begin
               // Both fire: the old main leaves, the new one replaces it.
               w_load_main = w_in_fire && w_out_fire;
               w_load_skid = w_in_fire && !w_out_fire;
            end
            S_TWO: begin
               w_load_main      = w_out_fire;
               w_main_from_skid = w_out_fire;
            end
            default: w_load_main = 1'b0;
         endcase
      end
   end

   assign main_d = w_main_from_skid ? skid_q : w_bundle;

   always_ff @(posedge clk) begin
      if (rst) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         if (w_load_main) main_q <= main_d;
         if (w_load_skid) skid_q <= w_bundle;
      end
   end

   assign {out_pc, rs1_id, rs2_id, rd_id, mem_width, imm, ctrl} = main_q;

`ifdef DECODE_STATS_EN
   logic [31:0] dec_count_q, illegal_count_q;

   // Every legal decode sets at least one ctrl bit, so ctrl==0 marks a bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         dec_count_q     <= '0;
         illegal_count_q <= '0;
      end else if (w_out_fire) begin
         if (ctrl != 16'h0000) dec_count_q     <= dec_count_q + 32'd1;
         if (ctrl[15])         illegal_count_q <= illegal_count_q + 32'd1;
      end
   end

   assign dec_count     = dec_count_q;
   assign illegal_count = illegal_count_q;
`endif

endmodule
`default_nettype wire
